// File: rtl/kernel3x3_sequencer.sv
// kernel3x3_sequencer: raster-stream front end for the 3x3 kernel datapath.
// Two line buffers plus a 3x3 window register feed an external combinational
// kernel; its result is captured in an output register stage with valid/ready.
module kernel3x3_sequencer #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] mode_in,
   output logic       busy,
   output logic       done,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [3:0] s_pix,
   output logic [1:0] k_mode,
   output logic [3:0] k_p1,
   output logic [3:0] k_p2,
   output logic [3:0] k_p3,
   output logic [3:0] k_p4,
   output logic [3:0] k_p5,
   output logic [3:0] k_p6,
   output logic [3:0] k_p7,
   output logic [3:0] k_p8,
   output logic [3:0] k_p9,
   input  logic [3:0] k_out,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [3:0] m_pix,
   output logic       m_last
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   state_t          state;
   logic [1:0]      mode_q;
   logic [RW-1:0]   row;
   logic [CW-1:0]   col;
   logic [3:0]      line_a [IMG_W];   // row r-2 at each column
   logic [3:0]      line_b [IMG_W];   // row r-1 at each column
   logic [2:0][3:0] w_top, w_mid, w_bot;  // index 2 is the newest column
   logic            win_valid, win_last;
   logic            accept, s2_load, at_end;

   // Output stage loads when a window is pending and the slot is free or draining.
   assign s2_load = win_valid && (!m_valid || m_ready);
   assign s_ready = (state == STREAM) && (!win_valid || s2_load);
   assign accept  = s_valid && s_ready;
   assign at_end  = (row == ROW_LAST) && (col == COL_LAST);

   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign k_mode = mode_q;
   assign k_p1 = w_top[0];
   assign k_p2 = w_top[1];
   assign k_p3 = w_top[2];
   assign k_p4 = w_mid[0];
   assign k_p5 = w_mid[1];
   assign k_p6 = w_mid[2];
   assign k_p7 = w_bot[0];
   assign k_p8 = w_bot[1];
   assign k_p9 = w_bot[2];

   // Frame control: mode latch, raster counters and state sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mode_q <= 2'd0;
         row    <= '0;
         col    <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               // Mode 3 is undefined in the kernel; fold it onto passthrough.
               mode_q <= (mode_in == 2'd3) ? 2'd2 : mode_in;
               row    <= '0;
               col    <= '0;
               state  <= STREAM;
            end
            STREAM: if (accept) begin
               if (col == COL_LAST) begin
                  col <= '0;
                  row <= row + RW'(1);
               end else begin
                  col <= col + CW'(1);
               end
               if (at_end) state <= DRAIN;
            end
            DRAIN: if (m_valid && m_ready && m_last) state <= DONE;
            DONE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Line buffers: each accept pushes the column one row up the history.
   always_ff @(posedge clk) begin
      if (accept) begin
         line_a[col] <= line_b[col];
         line_b[col] <= s_pix;
      end
   end

   // Window shift register and its pending flag (S1).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_top     <= '0;
         w_mid     <= '0;
         w_bot     <= '0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
      end else if (accept) begin
         w_top     <= {line_a[col], w_top[2:1]};
         w_mid     <= {line_b[col], w_mid[2:1]};
         w_bot     <= {s_pix,       w_bot[2:1]};
         // Only windows wholly inside the current frame are flagged.
         win_valid <= (row >= RW'(2)) && (col >= CW'(2));
         win_last  <= at_end;
      end else if (s2_load) begin
         win_valid <= 1'b0;
         win_last  <= 1'b0;
      end
   end

   // Result register (S2): capture kernel output, hold while the sink stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_pix   <= 4'd0;
         m_last  <= 1'b0;
      end else if (s2_load) begin
         m_valid <= 1'b1;
         m_pix   <= k_out;
         m_last  <= win_last;
      end else if (m_ready) begin
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_kernel3x3_sequencer.sv
// Directed bench for kernel3x3_sequencer: a 4x4 and an 8x8 instance share the
// stream inputs; sel8 picks which one is started and observed.
module tb_kernel3x3_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic sel8 = 1'b0;
   logic [1:0] mode_in = 2'd0;
   logic s_valid = 1'b0;
   logic [3:0] s_pix = 4'd0;
   logic m_ready = 1'b1;
   logic mrand = 1'b0;
   logic kchk = 1'b0;

   logic start4, start8;
   logic busy4, done4, s_ready4, m_valid4, m_last4;
   logic busy8, done8, s_ready8, m_valid8, m_last8;
   logic [1:0] k_mode4, k_mode8;
   logic [3:0] m_pix4, m_pix8, k_out4, k_out8;
   logic [3:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
   logic [3:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
   logic [8:0][3:0] kp4, kp8, kp;

   logic busy, done, s_ready, m_valid, m_last;
   logic [1:0] k_mode;
   logic [3:0] m_pix;

   int n_chk = 0;
   int n_pass = 0;
   int done_cnt = 0;
   logic [4:0] res_q[$];
   logic [3:0] exp_q[$];
   logic prev_stall = 1'b0, prev_done = 1'b0, prev_last = 1'b0;
   logic [3:0] prev_pix = 4'd0;

   always #5 clk = ~clk;

   // Reference kernel: 0 = box mean, 1 = |Laplacian| clamped, 2 = centre.
   function automatic logic [3:0] kern(input logic [1:0] m, input logic [8:0][3:0] p);
      int s;
      s = 0;
      for (int i = 0; i < 9; i++) s += int'(p[i]);
      case (m)
         2'd0: return 4'(s / 9);
         2'd1: begin
            s = 9 * int'(p[4]) - s;
            if (s < 0) s = -s;
            if (s > 15) s = 15;
            return 4'(s);
         end
         2'd2: return p[4];
         default: return 4'hf;
      endcase
   endfunction

   assign start4 = start && !sel8;
   assign start8 = start && sel8;
   assign kp4 = {a9, a8, a7, a6, a5, a4, a3, a2, a1};
   assign kp8 = {b9, b8, b7, b6, b5, b4, b3, b2, b1};
   assign k_out4 = kern(k_mode4, kp4);
   assign k_out8 = kern(k_mode8, kp8);

   assign busy    = sel8 ? busy8    : busy4;
   assign done    = sel8 ? done8    : done4;
   assign s_ready = sel8 ? s_ready8 : s_ready4;
   assign m_valid = sel8 ? m_valid8 : m_valid4;
   assign m_last  = sel8 ? m_last8  : m_last4;
   assign m_pix   = sel8 ? m_pix8   : m_pix4;
   assign k_mode  = sel8 ? k_mode8  : k_mode4;
   assign kp      = sel8 ? kp8      : kp4;

   kernel3x3_sequencer #(.IMG_W(4), .IMG_H(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .mode_in(mode_in),
      .busy(busy4), .done(done4), .s_valid(s_valid), .s_ready(s_ready4),
      .s_pix(s_pix), .k_mode(k_mode4),
      .k_p1(a1), .k_p2(a2), .k_p3(a3), .k_p4(a4), .k_p5(a5),
      .k_p6(a6), .k_p7(a7), .k_p8(a8), .k_p9(a9),
      .k_out(k_out4), .m_valid(m_valid4), .m_ready(m_ready),
      .m_pix(m_pix4), .m_last(m_last4)
   );

   kernel3x3_sequencer #(.IMG_W(8), .IMG_H(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .mode_in(mode_in),
      .busy(busy8), .done(done8), .s_valid(s_valid), .s_ready(s_ready8),
      .s_pix(s_pix), .k_mode(k_mode8),
      .k_p1(b1), .k_p2(b2), .k_p3(b3), .k_p4(b4), .k_p5(b5),
      .k_p6(b6), .k_p7(b7), .k_p8(b8), .k_p9(b9),
      .k_out(k_out8), .m_valid(m_valid8), .m_ready(m_ready),
      .m_pix(m_pix8), .m_last(m_last8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Sink ready: held high, or a pseudo-random pattern when mrand is set.
   always @(posedge clk) begin
      #1;
      m_ready = mrand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor on the falling edge: collect results, check stall hold.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_pix", m_pix, prev_pix);
            chk("stall_last", m_last, prev_last);
         end
         if (prev_done) chk("busy_after_done", busy, 0);
         if (kchk && busy) chk("k_mode_map", k_mode, 2);
         if (m_valid && m_ready) res_q.push_back({m_last, m_pix});
         if (done) done_cnt++;
         prev_stall = m_valid && !m_ready;
         prev_pix   = m_pix;
         prev_last  = m_last;
         prev_done  = done;
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_last"}, m_last, 0);
      chk({tag, "_m_pix"}, m_pix, 0);
      chk({tag, "_k_mode"}, k_mode, 0);
      chk({tag, "_k_p_lo"}, kp[7:0], 0);
      chk({tag, "_k_p_hi"}, kp[35:8], 0);
   endtask

   task automatic cmp_results(input string tag, input int base);
      chk({tag, "_count"}, res_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size() && base + i < res_q.size(); i++) begin
         chk({tag, "_pix"}, res_q[base + i][3:0], exp_q[i]);
         chk({tag, "_last"}, res_q[base + i][4], (i == exp_q.size() - 1));
      end
   endtask

   // Drive one frame; stop_after >= 0 abandons it after that many accepts.
   task automatic run_frame(input string tag, input logic s8, input logic [1:0] md,
                            input logic cst, input logic gaps, input logic hold,
                            input int stop_after);
      int n, idx, cyc, rbase, dbase;
      logic acc, seen;
      n = s8 ? 64 : 16;
      sel8 = s8;
      rbase = res_q.size();
      dbase = done_cnt;
      start = 1'b1;
      mode_in = md;
      @(negedge clk);
      chk({tag, "_ready_idle"}, s_ready, 0);
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      mode_in = 2'd1;
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 3000 && !(stop_after >= 0 && idx >= stop_after)) begin
         s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_pix = cst ? 4'd5 : 4'(idx);
         @(negedge clk);
         if (cyc == 0) chk({tag, "_ready_after_start"}, s_ready, 1);
         acc = s_valid && s_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      s_valid = 1'b0;
      chk({tag, "_accepted"}, idx, (stop_after >= 0) ? stop_after : n);
      if (stop_after < 0) begin
         seen = 1'b0;
         cyc = 0;
         while (!seen && cyc < 500) begin
            @(negedge clk);
            if (done) begin
               seen = 1'b1;
               start = 1'b0;
            end
            cyc++;
         end
         chk({tag, "_done_seen"}, seen, 1);
         start = 1'b0;
         repeat (4) @(posedge clk);
         #1;
         chk({tag, "_done_pulses"}, done_cnt - dbase, 1);
         chk({tag, "_busy_idle"}, busy, 0);
         cmp_results(tag, rbase);
      end
   endtask

   initial begin
      // Reset state on both instances.
      #2;
      sel8 = 1'b0;
      #1 chk_reset("rst4");
      sel8 = 1'b1;
      #1 chk_reset("rst8");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 4x4 ramp passthrough: centres 5, 6, 9, 10.
      exp_q = '{4'd5, 4'd6, 4'd9, 4'd10};
      run_frame("ramp4", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, -1);

      // 8x8 constant 5: box mean gives 5, Laplacian gives 0.
      exp_q.delete();
      for (int i = 0; i < 36; i++) exp_q.push_back(4'd5);
      run_frame("const8_m0", 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, -1);
      exp_q.delete();
      for (int i = 0; i < 36; i++) exp_q.push_back(4'd0);
      run_frame("const8_m1", 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, -1);

      // Mode 3 must reach the kernel as passthrough.
      exp_q = '{4'd5, 4'd6, 4'd9, 4'd10};
      kchk = 1'b1;
      run_frame("mode3", 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, -1);
      kchk = 1'b0;

      // Abort after 20 accepts: a result is pending, reset clears at once.
      run_frame("abort8", 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 20);
      chk("abort8_pending", m_valid, 1);
      rst_n = 1'b0;
      #1 chk_reset("abort8_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 8x8 ramp with input gaps and a stalling sink.
      exp_q.delete();
      for (int r = 1; r <= 6; r++)
         for (int c = 1; c <= 6; c++) exp_q.push_back(4'(8 * r + c));
      mrand = 1'b1;
      run_frame("ramp8_stall", 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, -1);
      mrand = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Fresh 4x4 frame after the abort.
      exp_q = '{4'd5, 4'd6, 4'd9, 4'd10};
      run_frame("post_rst4", 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, -1);

      // start held high across the whole frame: one frame, one done.
      run_frame("hold4", 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, -1);
      repeat (3) @(posedge clk);
      #1;
      chk("hold4_stays_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/kernel3x3_sequencer.md
# kernel3x3_sequencer

Raster-stream controller for the 3x3 convolution/edge kernel datapath. It accepts a frame of 4-bit pixels in raster order over a valid/ready input, keeps two line buffers, and builds each interior 3x3 window. It presents the window and a latched mode to the combinational kernel, captures the kernel's 4-bit result, and streams results out over a valid/ready output with frame start/done control. It sits between the pixel source (camera or BRAM reader) and the result sink (frame writer or display path).

## Interface
- IMG_W, 8, frame width in pixels; must be >= 3
- IMG_H, 8, frame height in pixels; must be >= 3
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin frame; sampled only in IDLE
- mode_in  in  2  kernel mode, latched on accepted start
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at frame end
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_pix  in  4  input pixel
- k_mode  out  2  mode to kernel
- k_p1 .. k_p9  out  4 each  window to kernel; p1..p3 row r-2, p4..p6 row r-1, p7..p9 row r; columns c-2, c-1, c left to right; p5 is the centre
- k_out  in  4  kernel result (combinational function of k_mode, k_p*)
- m_valid  out  1  result valid
- m_ready  in  1  sink ready
- m_pix  out  4  result pixel
- m_last  out  1  marks final result of frame, qualified by m_valid

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE: when start is high, mode_q <= (mode_in==3 ? 2 : mode_in). Modes 0 and 1 pass through unchanged. Mode 3 maps to 2 (passthrough) so the kernel never sees an undefined mode. On the same edge, row/col counters clear and the FSM goes to STREAM.
- STREAM: on each accept at (row r, col c):
  - window column registers shift left, then load {lineA[c], lineB[c], s_pix} into column 3.
  - lineA[c] <= lineB[c] and lineB[c] <= s_pix.
  - col increments. It wraps to 0 after IMG_W-1, and row then increments.
  - win_valid <= (r >= 2 && c >= 2); otherwise it clears when consumed.
  - The accept of (IMG_H-1, IMG_W-1) moves the FSM to DRAIN.
- Two-stage pipeline:
  - S1 holds the window registers and win_valid.
  - S2 holds m_pix, m_valid and m_last.
  - s2_load = win_valid && (!m_valid || m_ready). S2 loads m_pix <= k_out on s2_load.
  - s_ready = (state==STREAM) && (!win_valid || s2_load).
- m_last is set on the S2 load of the window centred at (IMG_H-2, IMG_W-2).
- DRAIN: no input accepted. Leaves to DONE on the cycle m_valid && m_ready && m_last.
- DONE: done=1 for exactly one cycle, then IDLE.
- k_mode = mode_q at all times. k_p* are driven directly from the window registers.
- Results per frame: (IMG_W-2)*(IMG_H-2), in raster order of window centre. Border pixels produce no output.
- Line buffers and window registers need no reset. Windows are only flagged valid once rows 0..2 and columns 0..2 of the current frame have been written.

## Timing
- Reset values: state=IDLE, busy=0, done=0, s_ready=0, m_valid=0, m_last=0, m_pix=0, k_mode=0, k_p*=0, win_valid=0, counters=0.
- Reset asserted mid-frame aborts immediately. No done pulse is produced and partial output is discarded. The next frame needs a new start.
- start to first s_ready: 1 cycle (start sampled at edge t, s_ready high during cycle t+1).
- Latency: pixel accepted at edge t completes its window at t+1, and m_valid rises after edge t+1 (2 edges) when the sink is ready.
- Throughput: 1 pixel/cycle with m_ready held high.
- m_valid && !m_ready holds m_pix and m_last stable. s_ready drops only when win_valid is also pending.
- start in STREAM, DRAIN or DONE is ignored. mode_in is ignored outside IDLE.
- Last accept to done: at least 3 cycles with m_ready high.

## Test plan
- 4x4 frame, mode_in=2, pixels 0..15 raster, m_ready=1 -> 4 results 5, 6, 9, 10, m_last on 10. done pulses once, and busy returns to 0 on the following cycle.
- 8x8 constant pixel 5, mode 0 -> 36 results, all 5. 8x8 constant 5, mode 1 -> 36 results, all 0. m_last only on the 36th result.
- mode_in=3, 4x4 ramp -> k_mode=2 throughout and results identical to the passthrough case.
- 8x8 ramp, mode 2, m_ready toggling with a pseudo-random pattern and s_valid gaps -> sequence matches the centre pixels in order, with no drop or duplicate. m_pix stays stable while stalled.
- Reset pulse after 20 accepted pixels -> all outputs at reset values immediately. A new 4x4 frame then yields the correct 4 results.
- start held high through a frame -> exactly one frame processed and one done pulse. The next frame begins only after DONE returns to IDLE.
